// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge-detect stage: FSM encodings, default
// geometry and a constant clog2 helper.
package sobel_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int DEF_FIFO_DATA_WIDTH = 32;
    localparam int DEF_IMG_WIDTH       = 720;
    localparam int DEF_IMG_HEIGHT      = 540;
    localparam int PIX_W               = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row-plus-two-pixel shift register feeding the 3x3 Sobel window.
// Tap [k] holds the pixel popped k+1 pops before the current one.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] tap_0,
    output logic [PIX_W-1:0] tap_1,
    output logic [PIX_W-1:0] tap_wm1,
    output logic [PIX_W-1:0] tap_w,
    output logic [PIX_W-1:0] tap_wp1,
    output logic [PIX_W-1:0] tap_2wm1,
    output logic [PIX_W-1:0] tap_2w,
    output logic [PIX_W-1:0] tap_2wp1
);

    localparam int DEPTH = 2 * IMG_WIDTH + 2;

    logic [PIX_W-1:0] line_r [DEPTH];

    // Shift register advancing one pixel per accepted pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_r[i] <= '0;
            end
        end else if (shift_en) begin
            line_r[0] <= pix_in;
            for (int i = 1; i < DEPTH; i++) begin
                line_r[i] <= line_r[i-1];
            end
        end
    end

    assign tap_0    = line_r[0];
    assign tap_1    = line_r[1];
    assign tap_wm1  = line_r[IMG_WIDTH-1];
    assign tap_w    = line_r[IMG_WIDTH];
    assign tap_wp1  = line_r[IMG_WIDTH+1];
    assign tap_2wm1 = line_r[2*IMG_WIDTH-1];
    assign tap_2w   = line_r[2*IMG_WIDTH];
    assign tap_2wp1 = line_r[2*IMG_WIDTH+1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel magnitude stage between two FWFT FIFOs, one output word per pixel.
// Optional binarization of the magnitude is enabled with `define SOBEL_THRESHOLD_EN.
module sobel_filter
    import sobel_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int THRESHOLD       = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       fifo_in_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_in_dout,
    input  logic                       fifo_in_empty,
    output logic                       fifo_out_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_out_din,
    input  logic                       fifo_out_full
);

    localparam int CNT_W = clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(IMG_WIDTH * IMG_HEIGHT - IMG_WIDTH - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(IMG_HEIGHT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic [CNT_W-1:0] row_r;
    logic [CNT_W-1:0] col_r;

    logic             rd_s;
    logic             wr_s;
    logic [PIX_W-1:0] y_s;
    logic [PIX_W-1:0] p00_s, p01_s, p02_s, p10_s, p12_s, p20_s, p21_s, p22_s;
    logic [PIX_W-1:0] unused_center_s;
    logic [FIFO_DATA_WIDTH-PIX_W-1:0] unused_dout_s;

    assign y_s           = fifo_in_dout[PIX_W-1:0];
    assign unused_dout_s = fifo_in_dout[FIFO_DATA_WIDTH-1:PIX_W];
    assign p22_s         = y_s;

    // The centre tap is not part of either Sobel kernel.
    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_line_buffer (
        .clock    (clock),
        .reset    (reset),
        .shift_en (fifo_in_rd_en),
        .pix_in   (y_s),
        .tap_0    (p21_s),
        .tap_1    (p20_s),
        .tap_wm1  (p12_s),
        .tap_w    (unused_center_s),
        .tap_wp1  (p10_s),
        .tap_2wm1 (p02_s),
        .tap_2w   (p01_s),
        .tap_2wp1 (p00_s)
    );

    // FIFO handshake: pop and push share one cycle while running.
    always_comb begin
        rd_s = 1'b0;
        wr_s = 1'b0;
        case (state_r)
            S_FILL: begin
                rd_s = !fifo_in_empty;
            end
            S_RUN: begin
                rd_s = !fifo_in_empty && !fifo_out_full;
                wr_s = !fifo_in_empty && !fifo_out_full;
            end
            S_DRAIN: begin
                wr_s = !fifo_out_full;
            end
            default: begin
                rd_s = 1'b0;
                wr_s = 1'b0;
            end
        endcase
    end

    assign fifo_in_rd_en  = reset && rd_s;
    assign fifo_out_wr_en = reset && wr_s;

    logic [10:0]        gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;
    logic signed [10:0] gx_s, gy_s;
    logic [9:0]         abs_gx_s, abs_gy_s;
    logic [11:0]        mag_sum_s;
    logic [10:0]        half_s;
    logic [PIX_W-1:0]   mag_s;
    logic [PIX_W-1:0]   out_pix_s;
    logic               border_s;

    assign gx_pos_s  = {3'b000, p02_s} + {2'b00, p12_s, 1'b0} + {3'b000, p22_s};
    assign gx_neg_s  = {3'b000, p00_s} + {2'b00, p10_s, 1'b0} + {3'b000, p20_s};
    assign gy_pos_s  = {3'b000, p20_s} + {2'b00, p21_s, 1'b0} + {3'b000, p22_s};
    assign gy_neg_s  = {3'b000, p00_s} + {2'b00, p01_s, 1'b0} + {3'b000, p02_s};
    assign gx_s      = $signed(gx_pos_s - gx_neg_s);
    assign gy_s      = $signed(gy_pos_s - gy_neg_s);
    assign abs_gx_s  = gx_s[10] ? 10'(-gx_s) : 10'(gx_s);
    assign abs_gy_s  = gy_s[10] ? 10'(-gy_s) : 10'(gy_s);
    assign mag_sum_s = {2'b00, abs_gx_s} + {2'b00, abs_gy_s};
    assign half_s    = mag_sum_s[11:1];
    assign mag_s     = (half_s > 11'd255) ? 8'hFF : half_s[7:0];

    assign border_s = (row_r == '0) || (row_r == ROW_LAST) ||
                      (col_r == '0) || (col_r == COL_LAST);

`ifdef SOBEL_THRESHOLD_EN
    logic [PIX_W-1:0] mag_final_s;
    assign mag_final_s = (int'(mag_s) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    logic [PIX_W-1:0] mag_final_s;
    logic [31:0]      unused_threshold_s;
    assign mag_final_s        = mag_s;
    assign unused_threshold_s = 32'(THRESHOLD);
`endif

    // Only interior centres in S_RUN carry a gradient; fill and drain output zero.
    always_comb begin
        out_pix_s = 8'h00;
        if (state_r == S_RUN && !border_s) begin
            out_pix_s = mag_final_s;
        end else begin
            out_pix_s = 8'h00;
        end
    end

    assign fifo_out_din = {{(FIFO_DATA_WIDTH-24){1'b0}}, out_pix_s, out_pix_s, out_pix_s};

    // Frame sequencer: pixel counter per phase plus centre row/col tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= S_FILL;
            pix_cnt_r <= '0;
            row_r     <= '0;
            col_r     <= '0;
        end else begin
            case (state_r)
                S_FILL: begin
                    if (rd_s) begin
                        if (pix_cnt_r == FILL_LAST) begin
                            state_r   <= S_RUN;
                            pix_cnt_r <= '0;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (wr_s) begin
                        if (pix_cnt_r == RUN_LAST) begin
                            state_r   <= S_DRAIN;
                            pix_cnt_r <= '0;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 1'b1;
                        end
                        if (col_r == COL_LAST) begin
                            col_r <= '0;
                            row_r <= row_r + 1'b1;
                        end else begin
                            col_r <= col_r + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wr_s) begin
                        if (pix_cnt_r == DRAIN_LAST) begin
                            state_r   <= S_FILL;
                            pix_cnt_r <= '0;
                            row_r     <= '0;
                            col_r     <= '0;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= S_FILL;
                    pix_cnt_r <= '0;
                    row_r     <= '0;
                    col_r     <= '0;
                end
            endcase
        end
    end

endmodule
